fixed_point_subtractor: RTL



---
 rtl/fixed_point_subtractor_if.sv | 32 +++
 rtl/fixed_point_subtractor.sv | 103 ++++++++++
 2 files changed

// File: rtl/fixed_point_subtractor_if.sv
// Operand/result handshake bundle for fixed_point_subtractor.
// master drives operands and out_ready; slave is the subtractor.
interface fixed_point_subtractor_if #(
  parameter int n1 = 8,
  parameter int m1 = 8,
  parameter int n2 = 8,
  parameter int m2 = 8
);
  localparam int MI = (n1 > n2) ? n1 : n2;
  localparam int MF = (m1 > m2) ? m1 : m2;
  localparam int W  = MI + MF + 1;

  logic [n1+m1-1:0] a;
  logic [n2+m2-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     diff;
  logic             neg;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, diff, neg, zero, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, diff, neg, zero, out_valid
  );
endinterface

// File: rtl/fixed_point_subtractor.sv
// Bit-serial a-b on binary-point-aligned unsigned operands, one result bit per clock.
// Optional FXSUB_SATURATE_EN floors negative results to zero on diff (neg/zero still exact).
module fixed_point_subtractor #(
  parameter int n1 = 8,
  parameter int m1 = 8,
  parameter int n2 = 8,
  parameter int m2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  fixed_point_subtractor_if.slave  sub_if
);
  localparam int MI  = (n1 > n2) ? n1 : n2;
  localparam int MF  = (m1 > m2) ? m1 : m2;
  localparam int W   = MI + MF + 1;
  localparam int CW  = $clog2(W);
  localparam int SHA = MF - m1;
  localparam int SHB = MF - m2;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, res_q;
  logic            br_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    diff_q;
  logic            neg_q, zero_q, out_valid_q;

  logic [W-1:0]    a_aln, b_aln;
  logic            d_bit, br_d;
  logic [W-1:0]    res_d, diff_d;

  // Zero-extend first, then shift, so the top bit of W stays clear for the sign.
  assign a_aln = {{(W-n1-m1){1'b0}}, sub_if.a} << SHA;
  assign b_aln = {{(W-n2-m2){1'b0}}, sub_if.b} << SHB;

  always_comb begin
    d_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d = {d_bit, res_q[W-1:1]};
`ifdef FXSUB_SATURATE_EN
    diff_d = res_d[W-1] ? '0 : res_d;
`else
    diff_d = res_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sub_if.in_valid) begin
            a_q     <= a_aln;
            b_q     <= b_aln;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          // Last bit lands in res_d this cycle, so outputs load from it directly.
          if (cnt_q == LAST) begin
            diff_q      <= diff_d;
            neg_q       <= res_d[W-1];
            zero_q      <= (res_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (sub_if.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sub_if.in_ready  = (state_q == IDLE);
  assign sub_if.diff      = diff_q;
  assign sub_if.neg       = neg_q;
  assign sub_if.zero      = zero_q;
  assign sub_if.out_valid = out_valid_q;
endmodule
